// File: rtl/text_overlay_pkg.sv
// text_overlay_pkg: shared address type, FSM states and buffer constants
// for the character-cell text overlay.
package text_overlay_pkg;

  localparam int TXT_ADDR_W = 13;
  localparam int TXT_DEPTH  = 8192;

  // Buffer address: row in the upper bits, column in the lower bits.
  typedef struct packed {
    logic [5:0] row;
    logic [6:0] col;
  } txt_addr_t;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } txt_state_t;

  function automatic txt_addr_t txtAddr(input logic [5:0] row, input logic [6:0] col);
    txt_addr_t a;
    a.row = row;
    a.col = col;
    return a;
  endfunction

endpackage

// File: rtl/text_ram.sv
// text_ram: simple dual-port 8192x8 RAM, one write port and one registered
// read port. A same-address read and write in one cycle returns the old byte.
module text_ram
  import text_overlay_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [TXT_ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]            wr_data_i,
  input  logic [TXT_ADDR_W-1:0] rd_addr_i,
  output logic [7:0]            rd_data_o
);

  logic [7:0] mem_q [TXT_DEPTH];
  logic [7:0] rd_data_q;

  // Write port: store one byte when enabled.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read port: registered output, sees the contents before this edge's write.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/text_overlay.sv
// text_overlay: character-cell text buffer and pixel compositor.
// Optional blinking cursor is enabled by defining TEXT_OVERLAY_CURSOR_EN.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int         COLS       = 106,
  parameter int         ROWS       = 60,
  parameter logic [7:0] CLR_CODE   = 8'h20,
  parameter int         BLINK_LOG2 = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blank,
  input  logic         vsync,
  input  logic [7:0]   char_x,
  input  logic [7:0]   char_y,
  input  logic [255:0] char_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [6:0]   wr_col,
  input  logic [5:0]   wr_row,
  input  logic [7:0]   wr_code,
  input  logic         clr_req,
  output logic         busy,
  output logic         err,
  output logic         pix_on,
  output logic         pix_blank
`ifdef TEXT_OVERLAY_CURSOR_EN
  ,
  input  logic [6:0]   cursor_col,
  input  logic [5:0]   cursor_row
`endif
);

  localparam logic [7:0] COLS_L = 8'(COLS);
  localparam logic [7:0] ROWS_L = 8'(ROWS);

  txt_state_t state_q, state_d;
  txt_addr_t  clr_addr_q, clr_addr_d;
  logic       err_q, err_d;
  logic       wrAccept, wrInRange;
  logic       ram_we;
  txt_addr_t  ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  txt_addr_t  rd_addr;
  logic       inRange;
  logic       inr_q, blank1_q;
  logic       pix_on_q, pix_on_d, pix_blank_q;
  logic       invert;

  assign wr_ready  = (state_q == ST_IDLE) && !clr_req;
  assign busy      = (state_q == ST_CLEAR);
  assign wrAccept  = wr_valid && wr_ready;
  assign wrInRange = ({1'b0, wr_col} < COLS_L) && ({2'b00, wr_row} < ROWS_L);

  // FSM and clear-address register; reset always starts a fresh clear sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      err_q      <= err_d;
    end
  end

  // Next state: a clear request always (re)starts the sweep; the sweep ends after the last address.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    err_d      = err_q;
    if (clr_req) begin
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_addr_q == '1) begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + 13'd1;
      end
    end
    if (wrAccept && !wrInRange) err_d = 1'b1;
  end

  // RAM write mux: the clear sweep owns the port while busy, otherwise in-range accepted writes.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_q;
    ram_wdata = CLR_CODE;
    if (state_q == ST_CLEAR) begin
      ram_we = reset;
    end else if (wrAccept && wrInRange) begin
      ram_we    = reset;
      ram_waddr = txtAddr(wr_row, wr_col);
      ram_wdata = wr_code;
    end
  end

  assign rd_addr = txtAddr(char_y[5:0], char_x[6:0]);
  assign inRange = (char_x < COLS_L) && (char_y < ROWS_L) && !blank;

  text_ram u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_data_i (ram_wdata),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rdata)
  );

`ifdef TEXT_OVERLAY_CURSOR_EN
  logic                vsync_q;
  logic [BLINK_LOG2:0] blink_q;
  logic                cur_q;
  logic                curHit;

  assign curHit = (char_x == {1'b0, cursor_col}) && (char_y == {2'b00, cursor_row});

  // Blink counter advances once per frame on the registered vsync rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_q <= 1'b0;
      blink_q <= '0;
      cur_q   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      cur_q   <= curHit;
      if (vsync && !vsync_q) blink_q <= blink_q + {{BLINK_LOG2{1'b0}}, 1'b1};
    end
  end

  assign invert = cur_q && blink_q[BLINK_LOG2];
`else
  logic unusedVsync;
  assign unusedVsync = vsync & (BLINK_LOG2 >= 0);
  assign invert      = 1'b0;
`endif

  // Pixel select once the code and the matching char_data have both arrived.
  always_comb begin
    pix_on_d = (char_data[ram_rdata] ^ invert) && inr_q;
  end

  // Two-stage pixel pipeline: range/blank alongside the RAM read, then the registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inr_q       <= 1'b0;
      blank1_q    <= 1'b1;
      pix_on_q    <= 1'b0;
      pix_blank_q <= 1'b1;
    end else begin
      inr_q       <= inRange;
      blank1_q    <= blank;
      pix_on_q    <= pix_on_d;
      pix_blank_q <= blank1_q;
    end
  end

  assign err       = err_q;
  assign pix_on    = pix_on_q;
  assign pix_blank = pix_blank_q;

endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: self-checking bench for text_overlay with a cell-array
// reference model. Cursor checks are included when TEXT_OVERLAY_CURSOR_EN is defined.
module tb_text_overlay;

  localparam int COLS = 106;
  localparam int ROWS = 60;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         blank = 1'b1;
  logic         vsync = 1'b0;
  logic [7:0]   char_x = '0;
  logic [7:0]   char_y = '0;
  logic [255:0] char_data = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [6:0]   wr_col = '0;
  logic [5:0]   wr_row = '0;
  logic [7:0]   wr_code = '0;
  logic         clr_req = 1'b0;
  logic         busy, err, pix_on, pix_blank;
`ifdef TEXT_OVERLAY_CURSOR_EN
  logic [6:0]   cursor_col = '0;
  logic [5:0]   cursor_row = '0;
`endif

  always #5 clk = ~clk;

  text_overlay #(.COLS(COLS), .ROWS(ROWS), .CLR_CODE(8'h20), .BLINK_LOG2(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .blank     (blank),
    .vsync     (vsync),
    .char_x    (char_x),
    .char_y    (char_y),
    .char_data (char_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_code   (wr_code),
    .clr_req   (clr_req),
    .busy      (busy),
    .err       (err),
    .pix_on    (pix_on),
    .pix_blank (pix_blank)
`ifdef TEXT_OVERLAY_CURSOR_EN
    ,
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
`endif
  );

  typedef struct {
    int x;
    int y;
    bit b;
  } cell_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model [64][128];
  int         frames = 0;
  cell_t      cellQ [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelClear();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++)
        model[r][c] = 8'h20;
  endfunction

  // Font stand-in: random pels; in font-like mode space is empty and 'A' is lit.
  function automatic logic [255:0] randData(input bit fontLike);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    if (fontLike) begin
      d[8'h20] = 1'b0;
      d[8'h41] = 1'b1;
    end
    return d;
  endfunction

  function automatic bit expectedPix(input int x, input int y, input bit b, input logic [255:0] data);
    bit v;
    if (x >= COLS || y >= ROWS || b) return 1'b0;
    v = data[model[y][x]];
`ifdef TEXT_OVERLAY_CURSOR_EN
    if (x == int'(cursor_col) && y == int'(cursor_row) && (frames % 64) >= 32) v = !v;
`endif
    return v;
  endfunction

  function automatic void pushCell(input int x, input int y, input bit b);
    cell_t c;
    c.x = x;
    c.y = y;
    c.b = b;
    cellQ.push_back(c);
  endfunction

  // Stream the queued cells through the pixel pipeline, checking each two cycles later.
  task automatic runScan(input string tag, input bit fontLike);
    int           n;
    bit           expQ [$];
    bit           blkQ [$];
    cell_t        cur, prev;
    logic [255:0] data;
    n = cellQ.size();
    prev.x = 0; prev.y = 0; prev.b = 1'b1;
    for (int k = 0; k < n + 2; k++) begin
      if (k >= 2) begin
        checkOutput({tag, "_pix"}, 32'(pix_on), 32'(expQ.pop_front()));
        checkOutput({tag, "_pblank"}, 32'(pix_blank), 32'(blkQ.pop_front()));
      end
      if (k >= 1 && k - 1 < n) begin
        data = randData(fontLike);
        char_data = data;
        expQ.push_back(expectedPix(prev.x, prev.y, prev.b, data));
        blkQ.push_back(prev.b);
      end
      if (k < n) begin
        cur    = cellQ[k];
        char_x = 8'(cur.x);
        char_y = 8'(cur.y);
        blank  = cur.b;
        prev   = cur;
      end else begin
        blank = 1'b1;
      end
      @(posedge clk); #1;
    end
    cellQ.delete();
  endtask

  // One write transaction, waiting (bounded) for wr_ready, then updating the model.
  task automatic applyStimulus(input int col, input int row, input logic [7:0] code, input string tag);
    int waited;
    wr_col   = 7'(col);
    wr_row   = 6'(row);
    wr_code  = code;
    wr_valid = 1'b1;
    waited   = 0;
    while (!wr_ready && waited < 20000) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput({tag, "_ready"}, 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (col < COLS && row < ROWS) model[row][col] = code;
  endtask

  task automatic waitClear(input string tag);
    int n;
    n = 0;
    while (busy && n < 9000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_cycles"}, 32'(n), 32'd8192);
    checkOutput({tag, "_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    modelClear();

    // Reset held low: outputs at their reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_pix", 32'(pix_on), 32'd0);
    checkOutput("rst_pblank", 32'(pix_blank), 32'd1);

    // Release: 8192-cycle initial clear.
    reset = 1'b1;
    waitClear("initclr");
    checkOutput("initclr_err", 32'(err), 32'd0);

    // Whole frame after the clear: all spaces, so no pels.
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 112; x++)
        pushCell(x, y, ($urandom_range(0, 7) == 0));
    runScan("frame0", 1'b1);

    // Single write of 'A' at col 3, row 2 with neighbours and boundaries.
    applyStimulus(3, 2, 8'h41, "wrA");
    pushCell(2, 2, 0); pushCell(3, 2, 0); pushCell(4, 2, 0);
    pushCell(3, 2, 1); pushCell(3, 2, 0); pushCell(3, 130, 0);
    runScan("cellA", 1'b1);

    // Out-of-range writes set the sticky error and change nothing.
    applyStimulus(110, 0, 8'h41, "oorCol");
    checkOutput("oorCol_err", 32'(err), 32'd1);
    applyStimulus(5, 62, 8'h41, "oorRow");
    applyStimulus(105, 59, 8'h41, "wrCorner");
    checkOutput("sticky_err", 32'(err), 32'd1);
    pushCell(105, 59, 0); pushCell(106, 59, 0); pushCell(105, 60, 0);
    pushCell(110, 0, 0); pushCell(5, 62, 0); pushCell(127, 63, 0);
    runScan("bounds", 1'b1);

    // Same-address read and write in one cycle returns the old code.
    char_x = 8'd7; char_y = 8'd7; blank = 1'b0;
    wr_col = 7'd7; wr_row = 6'd7; wr_code = 8'h41; wr_valid = 1'b1;
    #1;
    checkOutput("rw_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    blank = 1'b1;
    char_data = randData(1'b1);
    @(posedge clk); #1;
    checkOutput("rw_olddata", 32'(pix_on), 32'd0);
    model[7][7] = 8'h41;
    pushCell(7, 7, 0);
    runScan("rw_new", 1'b1);

    // Random cells with random pels.
    for (int i = 0; i < 600; i++)
      pushCell($urandom_range(0, 135), $urandom_range(0, 67), ($urandom_range(0, 7) == 0));
    runScan("rand1", 1'b0);

    // Clear/write collision: clear wins, write completes after the sweep.
    clr_req = 1'b1;
    wr_col = 7'd50; wr_row = 6'd30; wr_code = 8'h5A; wr_valid = 1'b1;
    #1;
    checkOutput("coll_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    clr_req = 1'b0;
    modelClear();
    checkOutput("coll_busy", 32'(busy), 32'd1);
    checkOutput("coll_ready_busy", 32'(wr_ready), 32'd0);
    waitClear("collclr");
    applyStimulus(50, 30, 8'h5A, "collWr");
    checkOutput("coll_err", 32'(err), 32'd1);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 112; x++)
        pushCell(x, y, ($urandom_range(0, 7) == 0));
    runScan("frame1", 1'b0);

`ifdef TEXT_OVERLAY_CURSOR_EN
    // Cursor at (0,0) over a space: lit for frames 32..63.
    for (int f = 0; f < 64; f++) begin
      pushCell(0, 0, 0); pushCell(1, 0, 0); pushCell(0, 0, 1); pushCell(0, 0, 0);
      runScan("cursor", 1'b1);
      vsync = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vsync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      frames++;
    end
`endif

    // Reset mid-operation flushes state and the pixel pipeline.
    pushCell(3, 2, 0);
    cellQ.delete();
    char_x = 8'd3; char_y = 8'd2; blank = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst2_err", 32'(err), 32'd0);
    checkOutput("rst2_busy", 32'(busy), 32'd1);
    checkOutput("rst2_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst2_pix", 32'(pix_on), 32'd0);
    checkOutput("rst2_pblank", 32'(pix_blank), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
